// File: rtl/vc_allocator.sv
// Virtual-channel allocator: one round-robin arbiter per output port grants a free
// downstream VC to at most one requesting input VC per cycle, with 1-cycle latency.
module vc_allocator #(
    parameter int unsigned PORT_NUM  = 5,
    parameter int unsigned VC_NUM    = 2,
    parameter int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [VC_NUM-1:0]    vc_request         [PORT_NUM],
    input  logic [PORT_SIZE-1:0] out_port           [PORT_NUM][VC_NUM],
    input  logic [VC_NUM-1:0]    idle_downstream_vc [PORT_NUM],
    output logic [VC_SIZE-1:0]   vc_new             [PORT_NUM][VC_NUM],
    output logic [VC_NUM-1:0]    vc_valid           [PORT_NUM]
);

    localparam int unsigned REQ_NUM  = PORT_NUM * VC_NUM;
    localparam int unsigned REQ_SIZE = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [VC_NUM-1:0]    avail      [PORT_NUM];
    logic [REQ_SIZE-1:0]  rr_ptr     [PORT_NUM];
    logic [REQ_NUM-1:0]   eligible;
    logic [PORT_SIZE-1:0] target     [REQ_NUM];
    logic [PORT_NUM-1:0]  win;
    logic [REQ_SIZE-1:0]  win_req    [PORT_NUM];
    logic [VC_SIZE-1:0]   win_vc     [PORT_NUM];
    logic [VC_NUM-1:0]    alloc_mask [PORT_NUM];

    // Masking by vc_valid stops a requester being granted again while it drops its request.
    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                eligible[p*VC_NUM+v] = vc_request[p][v] && (32'(out_port[p][v]) < PORT_NUM)
                                       && !vc_valid[p][v];
                target[p*VC_NUM+v]   = out_port[p][v];
            end
        end
    end

    always_comb begin
        logic                found;
        logic                free;
        int unsigned         idx;
        logic [REQ_SIZE-1:0] idx_r;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            win[o]        = 1'b0;
            win_req[o]    = '0;
            win_vc[o]     = '0;
            alloc_mask[o] = '0;
            found         = 1'b0;
            free          = 1'b0;
            idx           = 0;
            idx_r         = '0;
            // Scan requesters starting at the pointer, wrapping around once.
            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                idx = 32'(rr_ptr[o]) + i;
                if (idx >= REQ_NUM) idx = idx - REQ_NUM;
                idx_r = REQ_SIZE'(idx);
                if (!found && eligible[idx_r] && target[idx_r] == PORT_SIZE'(o)) begin
                    found      = 1'b1;
                    win_req[o] = idx_r;
                end
            end
            for (int unsigned k = 0; k < VC_NUM; k++) begin
                if (!free && avail[o][k]) begin
                    free      = 1'b1;
                    win_vc[o] = VC_SIZE'(k);
                end
            end
            if (found && free) begin
                win[o]                = 1'b1;
                alloc_mask[o][win_vc[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                vc_valid[p] <= '0;
                avail[p]    <= '1;
                rr_ptr[p]   <= '0;
                for (int unsigned v = 0; v < VC_NUM; v++) vc_new[p][v] <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                avail[o] <= (avail[o] & ~alloc_mask[o]) | idle_downstream_vc[o];
                if (win[o])
                    rr_ptr[o] <= (32'(win_req[o]) == REQ_NUM - 1) ? '0 : win_req[o] + 1'b1;
            end
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                for (int unsigned v = 0; v < VC_NUM; v++) begin
                    vc_valid[p][v] <= 1'b0;
                    for (int unsigned o = 0; o < PORT_NUM; o++) begin
                        if (win[o] && 32'(win_req[o]) == p*VC_NUM + v) begin
                            vc_valid[p][v] <= 1'b1;
                            vc_new[p][v]   <= win_vc[o];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: a table of per-cycle vectors with hand-computed grants,
// followed by a hand-written mid-allocation reset sequence.
module tb_vc_allocator;

    localparam int unsigned P = 5;
    localparam int unsigned V = 2;
    localparam int unsigned R = P * V;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [V-1:0]   vc_request         [P];
    logic [2:0]     out_port           [P][V];
    logic [V-1:0]   idle_downstream_vc [P];
    logic [0:0]     vc_new             [P][V];
    logic [V-1:0]   vc_valid           [P];

    vc_allocator #(.PORT_NUM(5), .VC_NUM(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .vc_request         (vc_request),
        .out_port           (out_port),
        .idle_downstream_vc (idle_downstream_vc),
        .vc_new             (vc_new),
        .vc_valid           (vc_valid)
    );

    always #5 clk = ~clk;

    // Flat index r = p*V+v for requests/grants; idle bit o*V+k frees VC k behind output o.
    typedef struct {
        string        name;
        logic [R-1:0] req;
        logic [3*R-1:0] tgt;
        logic [R-1:0] idle;
        logic [R-1:0] exp_valid;
        logic [R-1:0] exp_new;
    } vec_t;

    vec_t         vecs[$];
    int           tests = 0;
    int           fails = 0;
    logic [R-1:0] model_new = '0;

    function automatic logic [3*R-1:0] t(input int unsigned r, input int unsigned o);
        logic [3*R-1:0] f;
        f = 30'(o);
        return f << (3 * r);
    endfunction

    function automatic vec_t mk(input string n, input logic [R-1:0] req, input logic [3*R-1:0] tgt,
                                input logic [R-1:0] idle, input logic [R-1:0] ev,
                                input logic [R-1:0] en);
        vec_t x;
        x.name = n; x.req = req; x.tgt = tgt; x.idle = idle; x.exp_valid = ev; x.exp_new = en;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                vc_request[p][v]         = x.req[p*V+v];
                out_port[p][v]           = x.tgt[3*(p*V+v) +: 3];
                idle_downstream_vc[p][v] = x.idle[p*V+v];
            end
        end
    endtask

    task automatic run_check(input vec_t x);
        logic [R-1:0] av;
        logic [R-1:0] an;
        apply(x);
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                av[p*V+v] = vc_valid[p][v];
                an[p*V+v] = vc_new[p][v][0];
            end
        end
        model_new = (model_new & ~x.exp_valid) | (x.exp_new & x.exp_valid);
        tests++;
        if (av !== x.exp_valid) begin
            fails++;
            $display("FAIL %s vc_valid: got %b expected %b", x.name, av, x.exp_valid);
        end
        tests++;
        if (an !== model_new) begin
            fails++;
            $display("FAIL %s vc_new: got %b expected %b", x.name, an, model_new);
        end
    endtask

    initial begin
        logic [3*R-1:0] tg;

        // Single requester, then VC exhaustion and release timing on output 2 (r2 = p1,v0).
        tg = t(2, 2);
        vecs.push_back(mk("s1_first",      10'h004, tg, 10'h000, 10'h004, 10'h000));
        vecs.push_back(mk("s1_drop",       10'h000, tg, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("s1_second_vc1", 10'h004, tg, 10'h000, 10'h004, 10'h004));
        vecs.push_back(mk("s1_drop2",      10'h000, tg, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("s1_full_wait",  10'h004, tg, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("s4_rel_same",   10'h004, tg, 10'h020, 10'h000, 10'h000));
        vecs.push_back(mk("s4_rel_grant",  10'h004, tg, 10'h020, 10'h004, 10'h004));
        vecs.push_back(mk("s1_cleanup",    10'h000, tg, 10'h030, 10'h000, 10'h000));
        // Out-of-range target ports are never granted.
        vecs.push_back(mk("bad_port5",     10'h008, t(3, 5), 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("bad_port7",     10'h008, t(3, 7), 10'h000, 10'h000, 10'h000));
        // r0 and r7 share output 4 with per-grant releases, then a plain round-robin check.
        tg = t(0, 4) | t(7, 4);
        vecs.push_back(mk("s2_a", 10'h081, tg, 10'h000, 10'h001, 10'h000));
        vecs.push_back(mk("s2_b", 10'h081, tg, 10'h100, 10'h080, 10'h080));
        vecs.push_back(mk("s2_c", 10'h081, tg, 10'h200, 10'h001, 10'h000));
        vecs.push_back(mk("s2_d", 10'h081, tg, 10'h100, 10'h080, 10'h080));
        vecs.push_back(mk("s2_e", 10'h000, tg, 10'h200, 10'h000, 10'h000));
        vecs.push_back(mk("s2_rr_wrap", 10'h081, tg, 10'h000, 10'h001, 10'h000));
        vecs.push_back(mk("s2_g", 10'h000, tg, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("s2_rr_next", 10'h081, tg, 10'h000, 10'h080, 10'h080));
        vecs.push_back(mk("s2_i", 10'h000, tg, 10'h300, 10'h000, 10'h000));
        // Three requesters on output 1 with two VCs.
        tg = t(1, 1) | t(4, 1) | t(9, 1);
        vecs.push_back(mk("s3_a",        10'h212, tg, 10'h000, 10'h002, 10'h000));
        vecs.push_back(mk("s3_b",        10'h210, tg, 10'h000, 10'h010, 10'h010));
        vecs.push_back(mk("s3_wait",     10'h200, tg, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("s3_rel",      10'h200, tg, 10'h004, 10'h000, 10'h000));
        vecs.push_back(mk("s3_third",    10'h200, tg, 10'h000, 10'h200, 10'h000));
        vecs.push_back(mk("s3_cleanup",  10'h000, tg, 10'h00C, 10'h000, 10'h000));
        // Independent outputs 0, 2, 3 grant in the same cycle.
        tg = t(0, 0) | t(4, 2) | t(6, 3);
        vecs.push_back(mk("s5_parallel", 10'h051, tg, 10'h000, 10'h051, 10'h000));
        vecs.push_back(mk("s5_cleanup",  10'h000, tg, 10'h051, 10'h000, 10'h000));
        // Fill output 2 before the reset sequence (pointer ends at 4).
        tg = t(2, 2) | t(3, 2);
        vecs.push_back(mk("s6_fill_a",   10'h00C, tg, 10'h000, 10'h004, 10'h000));
        vecs.push_back(mk("s6_fill_b",   10'h008, tg, 10'h000, 10'h008, 10'h008));

        rst_n = 1'b0;
        apply(mk("idle", '0, '0, '0, '0, '0));
        @(posedge clk);
        run_check(mk("reset_state", '0, '0, '0, '0, '0));
        rst_n = 1'b1;

        foreach (vecs[i]) run_check(vecs[i]);

        // Reset while output 2 is exhausted and r3 is still requesting.
        rst_n     = 1'b0;
        model_new = '0;
        run_check(mk("s6_reset", 10'h008, t(3, 2), 10'h000, 10'h000, 10'h000));
        rst_n = 1'b1;
        // Pointer back at 0 picks r3 over r9; both VCs of output 2 free again.
        tg = t(3, 2) | t(9, 2);
        run_check(mk("s6_post_ptr",  10'h208, tg, 10'h000, 10'h008, 10'h000));
        run_check(mk("s6_post_vc1",  10'h208, tg, 10'h000, 10'h200, 10'h200));
        run_check(mk("s6_post_idle", 10'h000, tg, 10'h000, 10'h000, 10'h000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
